// File: rtl/rle_compressor.sv
// rle_compressor: run-length encodes a 16-bit sample stream into literal and count words.
// Two equal samples in a row are both sent as literals and open a run; further repeats
// are counted and closed by count words (0xffff = 65535 repeats, more to follow).
module rle_compressor (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] din,
   input  logic        din_strobe,
   input  logic        flush,
   output logic [15:0] dout,
   output logic        dout_strobe,
   output logic        overrun,
   output logic        busy
);

   localparam int unsigned W = 16;
   localparam logic [W-1:0] CNT_WRAP  = W'(16'hfffe);
   localparam logic [W-1:0] CNT_CONT  = W'(16'hffff);

   typedef enum logic [1:0] {IDLE, LIT, RUN} state_t;

   state_t         state, state_n;
   logic [W-1:0]   cnt, cnt_n;
   logic [W-1:0]   last, last_n;
   logic [W-1:0]   hold, hold_n;
   logic           hold_vld, hold_vld_n;
   logic           flush_pend, flush_pend_n;
   logic           prev_acc;
   logic           emit;
   logic [W-1:0]   word;
   logic           accept;
   logic           flush_req;
   logic           flush_apply;

   // A strobe right after an accepted one violates spacing and is dropped.
   assign accept      = din_strobe & ~prev_acc;
   assign flush_req   = flush | flush_pend;
   assign flush_apply = flush_req & ~accept & ~hold_vld;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Next-state logic.
   always_comb begin
      state_n = state;
      if (accept) begin
         case (state)
            IDLE:    state_n = LIT;
            LIT:     if (din == last) state_n = RUN;
            RUN:     if (din != last) state_n = LIT;
            default: state_n = IDLE;
         endcase
      end else if (flush_apply && state == RUN) begin
         state_n = IDLE;
      end
   end

   // Word selection and datapath updates.
   always_comb begin
      emit         = 1'b0;
      word         = '0;
      cnt_n        = cnt;
      last_n       = last;
      hold_n       = hold;
      hold_vld_n   = 1'b0;
      flush_pend_n = flush_req & ~flush_apply;
      if (accept) begin
         case (state)
            IDLE: begin
               emit   = 1'b1;
               word   = din;
               last_n = din;
            end
            LIT: begin
               emit = 1'b1;
               word = din;
               if (din == last) cnt_n  = '0;
               else             last_n = din;
            end
            RUN: begin
               if (din == last) begin
                  if (cnt == CNT_WRAP) begin
                     emit  = 1'b1;
                     word  = CNT_CONT;
                     cnt_n = '0;
                  end else begin
                     cnt_n = W'(cnt + W'(1));
                  end
               end else begin
                  // Close the run now; the new sample follows one cycle later.
                  emit       = 1'b1;
                  word       = cnt;
                  hold_n     = din;
                  hold_vld_n = 1'b1;
                  last_n     = din;
               end
            end
            default: ;
         endcase
      end else if (hold_vld) begin
         emit = 1'b1;
         word = hold;
      end else if (flush_apply && state == RUN) begin
         emit = 1'b1;
         word = cnt;
      end
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         last        <= '0;
         hold        <= '0;
         hold_vld    <= 1'b0;
         flush_pend  <= 1'b0;
         prev_acc    <= 1'b0;
         dout        <= '0;
         dout_strobe <= 1'b0;
         overrun     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         cnt         <= cnt_n;
         last        <= last_n;
         hold        <= hold_n;
         hold_vld    <= hold_vld_n;
         flush_pend  <= flush_pend_n;
         prev_acc    <= accept;
         dout_strobe <= emit;
         if (emit) dout <= word;
         if (din_strobe && prev_acc) overrun <= 1'b1;
         busy        <= (state_n == RUN) | hold_vld_n | flush_pend_n;
      end
   end

endmodule

// File: doc/rle_compressor.md
Name: rle_compressor

Overview:
- Run-length compresses the raw 16-bit sample stream from the sampler into the word stream that the index scanner consumes.
- Sits directly upstream of the index scanner.
- Encoding:
  - A sample that differs from its predecessor is emitted as a literal.
  - A second consecutive identical sample is also emitted, and then opens a run.
  - A run is closed by count words giving the number of further repeats.
  - A count word of 0xffff means 65535 repeats plus another count word follows.
  - A count word below 0xffff terminates the run.

Parameters:
- none. Word width is fixed at 16 to match the index scanner.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- din  in  16  raw sample
- din_strobe  in  1  din valid this cycle; strobes are at least 2 cycles apart
- flush  in  1  request to close any open run
- dout  out  16  compressed word (literal or count)
- dout_strobe  out  1  dout valid, single-cycle pulse
- overrun  out  1  sticky: strobe spacing violated
- busy  out  1  high when a run is open, or a held literal or pending flush exists

Behaviour:
- Reset (async, rst_n low) values:
  - dout=0, dout_strobe=0, overrun=0.
  - state=IDLE, cnt=0, last=0, hold empty, flush_pend=0.
  - Reset mid-run discards the open run and any held word.
- Outputs are registered. dout_strobe is high for exactly one cycle per word, and at most one word is emitted per cycle.
- Latency: a word caused by a strobe in cycle T appears in T+1.
- State machine, per accepted strobe with sample s:
  - IDLE: emit s; last<=s; go to LIT. No comparison is made in IDLE.
  - LIT:
    - If s==last: emit s, cnt<=0, go to RUN.
    - Else: emit s, last<=s, stay in LIT.
  - RUN, s==last: no literal.
    - If cnt==0xfffe: emit 0xffff, cnt<=0, stay in RUN.
    - Else: cnt<=cnt+1, no output.
  - RUN, s!=last:
    - Emit cnt in T+1 and load hold<=s.
    - In T+2, emit hold; last<=s; go to LIT.
- The count word is always ≤0xfffe except the 0xffff continuation.
- Strobe spacing:
  - Because strobes are ≥2 cycles apart, hold is always empty when the next strobe arrives.
  - A strobe in the cycle immediately after an accepted strobe is dropped, and sets overrun=1.
  - overrun stays set until reset.
- Flush:
  - A flush pulse sets flush_pend.
  - flush_pend is applied in the first cycle with no strobe and an empty hold.
  - Applied in RUN: emit cnt, go to IDLE.
  - Applied in IDLE or LIT: no-op, no output; state is unchanged, so a following equal sample in LIT still forms a pair.
  - flush_pend clears when applied.
  - A flush coincident with a strobe is deferred (not lost).
- busy = (state==RUN) | hold valid | flush_pend.
- Decoder consistency: the sum over words of (1 per literal + count value) equals the number of accepted input samples after each terminating count.

Test Plan:
1. Strobe every 2 cycles with 0x0001, 0x0002, 0x0003 -> dout 0x0001, 0x0002, 0x0003. Each dout_strobe falls 1 cycle after its din_strobe.
2. 0x0005 ×4 then 0x0007 -> dout 0x0005, 0x0005, 0x0002, 0x0007. 0x0002 appears 1 cycle after the 0x0007 strobe; 0x0007 appears on the next cycle.
3. 0x0005, 0x0005, 0x0007 -> 0x0005, 0x0005, 0x0000, 0x0007.
4. 65540 × 0x0009 then 0x0001 -> 0x0009, 0x0009, 0xffff, then on the 0x0001 strobe 0x0003 followed by 0x0001. The 0xffff is emitted 1 cycle after the 65537th sample.
5. 0x0004 ×3, then flush pulse -> 0x0004, 0x0004, 0x0001, and busy falls. Then 0x0004, 0x0004 -> 0x0004, 0x0004 (pair, state RUN).
6. Strobes on two consecutive cycles (0x00AA then 0x00BB) -> only 0x00AA emitted and overrun=1 held. Then assert rst_n low mid-run -> all outputs 0 and overrun=0 immediately.
